// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - instruction fetch unit: one outstanding imem request, redirect-aware
// Holds the fetched word for decode; misaligned redirects yield a faulted NOP without a fetch.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        imem_resp_err,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_fault
);

  localparam logic [1:0]  S_REQ   = 2'd0;
  localparam logic [1:0]  S_WAIT  = 2'd1;
  localparam logic [1:0]  S_OUT   = 2'd2;
  localparam logic [1:0]  S_DRAIN = 2'd3;
  localparam logic [31:0] NOP     = 32'h0000_0013;

  logic [1:0]  r_state;
  logic [31:0] r_pc;
  logic [31:0] r_inst;
  logic [31:0] r_inst_pc;
  logic        r_inst_fault;
  // Set while a faulted NOP sits in OUT but an abandoned response is still due.
  logic        r_stale;

  logic        w_hs;
  logic        w_misaligned;
  logic [31:0] w_pc_seq;
  logic        w_pend;

  assign imem_req_valid = (r_state == S_REQ) & ~rst;
  assign imem_req_addr  = r_pc;
  assign inst_valid     = (r_state == S_OUT);
  assign inst           = r_inst;
  assign inst_pc        = r_inst_pc;
  assign inst_fault     = r_inst_fault;

  assign w_hs         = imem_req_valid & imem_req_ready;
  assign w_misaligned = (redirect_pc[1:0] != 2'b00);
  // Sequential PC is forced back to word alignment even after a misaligned redirect.
  assign w_pc_seq     = {r_pc[31:2] + 30'd1, 2'b00};

  // A memory response is still owed after this cycle.
  always_comb begin
    w_pend = 1'b0;
    case (r_state)
      S_REQ:   w_pend = w_hs;
      S_WAIT:  w_pend = ~imem_resp_valid;
      S_DRAIN: w_pend = ~imem_resp_valid;
      default: w_pend = r_stale & ~imem_resp_valid;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_REQ;
      r_pc         <= RESET_PC;
      r_inst       <= 32'd0;
      r_inst_pc    <= 32'd0;
      r_inst_fault <= 1'b0;
      r_stale      <= 1'b0;
    end else if (redirect_valid) begin
      r_pc <= redirect_pc;
      if (w_misaligned) begin
        r_state      <= S_OUT;
        r_inst       <= NOP;
        r_inst_pc    <= redirect_pc;
        r_inst_fault <= 1'b1;
        r_stale      <= w_pend;
      end else begin
        r_state <= w_pend ? S_DRAIN : S_REQ;
        r_stale <= 1'b0;
      end
    end else begin
      case (r_state)
        S_REQ: begin
          if (w_hs) r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (imem_resp_valid) begin
            r_inst       <= imem_resp_err ? NOP : imem_resp_data;
            r_inst_pc    <= r_pc;
            r_inst_fault <= imem_resp_err;
            r_state      <= S_OUT;
          end
        end
        S_OUT: begin
          if (inst_ready) begin
            r_pc    <= w_pc_seq;
            r_state <= (r_stale & ~imem_resp_valid) ? S_DRAIN : S_REQ;
            r_stale <= 1'b0;
          end else if (imem_resp_valid) begin
            r_stale <= 1'b0;
          end
        end
        default: begin
          if (imem_resp_valid) r_state <= S_REQ;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// tb/tb_ifu_fetch.sv - directed and randomized bench for ifu_fetch with a stream-level scoreboard
module tb_ifu_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid, imem_resp_err;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid, inst_ready, inst_fault;
  logic [31:0] inst, inst_pc;

  int n_checks = 0;
  int n_fail   = 0;
  int n_xfer   = 0;

  logic [31:0] exp_pc;
  logic        slot_busy;
  logic [31:0] slot_addr;
  int          slot_cnt;
  int          mem_lat;
  logic        err_en, err_force;
  logic        hold_valid;
  logic [31:0] hold_inst, hold_pc;

  ifu_fetch #(.RESET_PC(32'h8000_0000)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data), .imem_resp_err(imem_resp_err),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc), .inst_fault(inst_fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a == 32'h8000_0000) ? 32'h0010_0093 : (a ^ 32'hA5C3_0F01);
  endfunction

  function automatic logic mem_err(input logic [31:0] a);
    return err_force | (err_en & (a[6:2] == 5'd7));
  endfunction

  task automatic model_reset();
    exp_pc     = 32'h8000_0000;
    slot_busy  = 1'b0;
    slot_cnt   = 0;
    hold_valid = 1'b0;
    imem_resp_valid = 1'b0;
  endtask

  // One clock: drive inputs after the edge, sample and score at the falling edge.
  task automatic cycle(input logic rdy, input logic irdy, input logic rv, input logic [31:0] rpc);
    logic [31:0] e_inst;
    logic        e_fault;
    @(posedge clk); #1;
    imem_req_ready = rdy;
    inst_ready     = irdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    if (slot_busy && slot_cnt == 0) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_data(slot_addr);
      imem_resp_err   = mem_err(slot_addr);
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = $urandom;
      imem_resp_err   = 1'($urandom);
    end
    @(negedge clk);
    if (hold_valid && inst_valid) begin
      check("hold_inst", inst, hold_inst);
      check("hold_pc", inst_pc, hold_pc);
    end
    hold_valid = inst_valid & ~inst_ready & ~redirect_valid;
    hold_inst  = inst;
    hold_pc    = inst_pc;
    if (imem_resp_valid) slot_busy = 1'b0;
    else if (slot_busy) slot_cnt--;
    if (imem_req_valid && imem_req_ready) begin
      check("single_outstanding", {31'd0, slot_busy}, 32'd0);
      check("req_addr", imem_req_addr, exp_pc);
      check("req_aligned", {30'd0, imem_req_addr[1:0]}, 32'd0);
      slot_busy = 1'b1;
      slot_addr = imem_req_addr;
      slot_cnt  = (mem_lat < 0) ? int'($urandom_range(0, 2)) : mem_lat;
    end
    if (inst_valid && inst_ready) begin
      if (exp_pc[1:0] != 2'b00 || mem_err(exp_pc)) begin
        e_inst = 32'h0000_0013; e_fault = 1'b1;
      end else begin
        e_inst = mem_data(exp_pc); e_fault = 1'b0;
      end
      check("xfer_pc", inst_pc, exp_pc);
      check("xfer_inst", inst, e_inst);
      check("xfer_fault", {31'd0, inst_fault}, {31'd0, e_fault});
      exp_pc = {exp_pc[31:2] + 30'd1, 2'b00};
      n_xfer++;
    end
    if (redirect_valid) exp_pc = redirect_pc;
  endtask

  initial begin
    logic [31:0] rpc;
    rst = 1'b1; imem_req_ready = 0; inst_ready = 0; redirect_valid = 0; redirect_pc = 0;
    imem_resp_data = 0; imem_resp_err = 0;
    err_en = 0; err_force = 0; mem_lat = 0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    check("rst_inst", inst, 32'd0);
    check("rst_inst_pc", inst_pc, 32'd0);
    check("rst_fault", {31'd0, inst_fault}, 32'd0);
    rst = 1'b0;

    cycle(1, 0, 0, 0);
    check("first_req_valid", {31'd0, imem_req_valid}, 32'd1);
    check("first_req_addr", imem_req_addr, 32'h8000_0000);
    cycle(0, 0, 0, 0);
    check("wait_no_valid", {31'd0, inst_valid}, 32'd0);
    cycle(0, 0, 0, 0);
    check("out_valid", {31'd0, inst_valid}, 32'd1);
    check("out_inst", inst, 32'h0010_0093);
    check("out_pc", inst_pc, 32'h8000_0000);
    check("out_fault", {31'd0, inst_fault}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      cycle(1, 0, 0, 0);
      check("stall_inst", inst, 32'h0010_0093);
      check("stall_pc", inst_pc, 32'h8000_0000);
      check("stall_no_req", {31'd0, imem_req_valid}, 32'd0);
    end
    cycle(0, 1, 0, 0);
    cycle(0, 0, 0, 0);
    check("seq_req_valid", {31'd0, imem_req_valid}, 32'd1);
    check("seq_req_addr", imem_req_addr, 32'h8000_0004);

    mem_lat = 2;
    cycle(1, 0, 0, 0);
    cycle(0, 0, 1, 32'h8000_0100);
    cycle(0, 0, 0, 0);
    check("drain_no_req", {31'd0, imem_req_valid}, 32'd0);
    check("drain_no_valid", {31'd0, inst_valid}, 32'd0);
    cycle(0, 0, 0, 0);
    check("drop_no_valid", {31'd0, inst_valid}, 32'd0);
    cycle(0, 0, 0, 0);
    check("redir_req_valid", {31'd0, imem_req_valid}, 32'd1);
    check("redir_req_addr", imem_req_addr, 32'h8000_0100);
    check("redir_no_valid", {31'd0, inst_valid}, 32'd0);

    mem_lat = 0; err_force = 1;
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    check("err_inst", inst, 32'h0000_0013);
    check("err_fault", {31'd0, inst_fault}, 32'd1);
    check("err_pc", inst_pc, 32'h8000_0100);
    cycle(0, 0, 1, 32'h8000_0102);
    cycle(0, 0, 0, 0);
    check("mis_valid", {31'd0, inst_valid}, 32'd1);
    check("mis_pc", inst_pc, 32'h8000_0102);
    check("mis_fault", {31'd0, inst_fault}, 32'd1);
    check("mis_inst", inst, 32'h0000_0013);
    check("mis_no_req", {31'd0, imem_req_valid}, 32'd0);
    err_force = 0;
    cycle(0, 1, 0, 0);
    cycle(0, 0, 0, 0);
    check("mis_next_addr", imem_req_addr, 32'h8000_0104);

    cycle(0, 0, 1, 32'hFFFF_FFFC);
    cycle(1, 0, 0, 0);
    check("top_req_addr", imem_req_addr, 32'hFFFF_FFFC);
    cycle(0, 0, 0, 0);
    cycle(0, 1, 0, 0);
    check("top_inst_pc", inst_pc, 32'hFFFF_FFFC);
    cycle(0, 0, 0, 0);
    check("wrap_req_valid", {31'd0, imem_req_valid}, 32'd1);
    check("wrap_req_addr", imem_req_addr, 32'h0000_0000);

    mem_lat = 2;
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("mid_rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check("mid_rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    check("mid_rst_inst", inst, 32'd0);
    check("mid_rst_inst_pc", inst_pc, 32'd0);
    check("mid_rst_fault", {31'd0, inst_fault}, 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    cycle(1, 0, 0, 0);
    check("post_rst_req_valid", {31'd0, imem_req_valid}, 32'd1);
    check("post_rst_req_addr", imem_req_addr, 32'h8000_0000);

    mem_lat = -1; err_en = 1;
    for (int i = 0; i < 4000; i++) begin
      rpc = {24'h800000, 6'($urandom), 2'b00};
      case ($urandom_range(0, 7))
        0: rpc = {30'h3FFF_FFFC | 30'($urandom_range(0, 3)), 2'b00};
        1: rpc = {30'($urandom), 2'($urandom_range(1, 3))};
        default: ;
      endcase
      cycle(($urandom_range(0, 9) < 6), 1'($urandom), ($urandom_range(0, 99) < 8), rpc);
    end
    check("progress", {31'd0, n_xfer > 200}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
